// File: rtl/rgb_pixel_mem_if.sv
// rgb_pixel_mem_if: load/store request channel and response channel of the pixel memory
interface rgb_pixel_mem_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_rgb;
  logic [ADDR_W-1:0] req_addr;
  logic [23:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [23:0]       rsp_data;
  logic              wr_done;
  modport master (
    output req_valid, req_we, req_rgb, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, wr_done
  );
  modport slave (
    input  req_valid, req_we, req_rgb, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, wr_done
  );
endinterface

// File: rtl/rgb_pixel_mem.sv
// rgb_pixel_mem: pixel RAM responder with per-channel read-modify-write stores
module rgb_pixel_mem #(
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 24
) (
  input logic clk,
  input logic rst,
  rgb_pixel_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, MERGE, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        rgb_q;
  logic [PIX_W-1:0]  wdata_q, rd_q, merged, lane;
  logic              rsp_valid, wr_done;
  logic [PIX_W-1:0]  rsp_data;
  logic [PIX_W-1:0]  mem [2**ADDR_W];
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.wr_done   = wr_done;
  // next state: accept in IDLE, fixed fetch/merge, hold RESP until consumed
  always_comb begin
    state_n = state == IDLE  ? (bus.req_valid ? FETCH : IDLE) :
              state == FETCH ? MERGE :
              state == MERGE ? (we_q ? IDLE : RESP) :
                               (bus.rsp_ready ? IDLE : RESP);
  end
  // store merge into the selected lane and load lane extraction (zero-extended)
  always_comb begin
    merged = rgb_q == 2'b00 ? wdata_q :
             rgb_q == 2'b01 ? {wdata_q[7:0], rd_q[15:0]} :
             rgb_q == 2'b10 ? {rd_q[23:16], wdata_q[7:0], rd_q[7:0]} :
                              {rd_q[23:8], wdata_q[7:0]};
    lane   = rgb_q == 2'b00 ? rd_q :
             rgb_q == 2'b01 ? {{(PIX_W-8){1'b0}}, rd_q[23:16]} :
             rgb_q == 2'b10 ? {{(PIX_W-8){1'b0}}, rd_q[15:8]} :
                              {{(PIX_W-8){1'b0}}, rd_q[7:0]};
  end
  // state, latched request and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      rgb_q     <= 2'b00;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      wr_done   <= 1'b0;
    end else begin
      state   <= state_n;
      wr_done <= state == MERGE && we_q;
      if (state == IDLE && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        we_q    <= bus.req_we;
        rgb_q   <= bus.req_rgb;
        wdata_q <= bus.req_wdata;
      end
      if (state == MERGE && !we_q) begin
        rsp_valid <= 1'b1;
        rsp_data  <= lane;
      end else if (state == RESP && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
  // pixel RAM: registered read in FETCH, write-back in MERGE unless reset aborts it
  always_ff @(posedge clk) begin
    if (state == MERGE && we_q && !rst) mem[addr_q] <= merged;
    if (state == FETCH) rd_q <= mem[addr_q];
  end
endmodule

// File: tb/tb_rgb_pixel_mem.sv
// tb_rgb_pixel_mem: randomized and directed checks of rgb_pixel_mem against a byte-lane model
module tb_rgb_pixel_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_q[$];
  int wd_q[$];
  logic [7:0] px [1024][3];
  logic [9:0] pool [8] = '{10'd0, 10'd1, 10'd2, 10'd5, 10'd9, 10'd511, 10'd1022, 10'd1023};
  rgb_pixel_mem_if #(.ADDR_W(10)) bus ();
  rgb_pixel_mem #(.ADDR_W(10), .PIX_W(24)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.req_valid && bus.req_ready && !rst) acc_q.push_back(cyc);
    if (bus.wr_done) wd_q.push_back(cyc);
    cyc++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] mload(input logic [1:0] c, input logic [9:0] a);
    return c == 2'd0 ? {px[a][0], px[a][1], px[a][2]} : {16'h0, px[a][c-2'd1]};
  endfunction
  task automatic mstore(input logic [1:0] c, input logic [9:0] a, input logic [23:0] wd);
    if (c == 2'd0) begin
      px[a][0] = wd[23:16];
      px[a][1] = wd[15:8];
      px[a][2] = wd[7:0];
    end else px[a][c-2'd1] = wd[7:0];
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic we, input logic [1:0] rgb, input logic [9:0] a,
                      input logic [23:0] wd, input int stall, output logic [23:0] rd);
    logic [23:0] e;
    bit ok;
    e = mload(rgb, a);
    rd = '0;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_rgb = rgb;
    bus.req_addr = a;
    bus.req_wdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    bus.req_addr = 10'($urandom);
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    chk("busy_fetch", bus.req_ready, 0);
    tick();
    chk("quiet_merge", {bus.rsp_valid, bus.wr_done, bus.req_ready}, 0);
    tick();
    if (we) begin
      mstore(rgb, a, wd);
      chk("wr_done", bus.wr_done, 1);
      chk("ready_after_st", bus.req_ready, 1);
      chk("no_rsp_on_st", bus.rsp_valid, 0);
      tick();
      chk("wr_done_clear", bus.wr_done, 0);
    end else begin
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_data", bus.rsp_data, e);
      chk("busy_resp", bus.req_ready, 0);
      rd = bus.rsp_data;
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("hold_valid", bus.rsp_valid, 1);
        chk("hold_data", bus.rsp_data, e);
        chk("hold_busy", bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("rsp_drop", bus.rsp_valid, 0);
      chk("ready_back", bus.req_ready, 1);
      chk("data_keep", bus.rsp_data, e);
    end
  endtask
  task automatic wait_acc(input int n);
    for (int i = 0; i < 20 && acc_q.size() < n; i++) tick();
    if (acc_q.size() < n) chk("b2b_accept_timeout", acc_q.size(), n);
  endtask
  initial begin
    logic [23:0] rd;
    logic [23:0] before9;
    int n;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_rgb = 2'b00;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_wr_done", bus.wr_done, 0);
    rst = 1'b0;
    tick();
    foreach (pool[i]) xfer(1'b1, 2'b00, pool[i], 24'h0, 0, rd);
    xfer(1'b1, 2'b00, 10'd5, 24'hA1B2C3, 0, rd);
    xfer(1'b0, 2'b00, 10'd5, 24'h0, 0, rd);
    chk("full_readback", rd, 24'hA1B2C3);
    xfer(1'b1, 2'b10, 10'd5, 24'hFFFF7E, 0, rd);
    xfer(1'b0, 2'b00, 10'd5, 24'h0, 0, rd);
    chk("stg_merge", rd, 24'hA17EC3);
    xfer(1'b0, 2'b01, 10'd5, 24'h0, 0, rd);
    chk("ldr", rd, 24'h0000A1);
    xfer(1'b0, 2'b11, 10'd5, 24'h0, 0, rd);
    chk("ldb", rd, 24'h0000C3);
    xfer(1'b0, 2'b10, 10'd5, 24'h0, 4, rd);
    chk("ldg_stalled", rd, 24'h00007E);
    acc_q.delete();
    wd_q.delete();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_rgb = 2'b01;
    bus.req_addr = 10'd0;
    bus.req_wdata = 24'h000011;
    wait_acc(1);
    bus.req_rgb = 2'b11;
    bus.req_wdata = 24'h000022;
    wait_acc(2);
    bus.req_we = 1'b0;
    bus.req_rgb = 2'b00;
    wait_acc(3);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      tick();
      n++;
    end
    chk("b2b_rsp_valid", bus.rsp_valid, 1);
    chk("b2b_rsp_data", bus.rsp_data, 24'h110022);
    tick();
    bus.rsp_ready = 1'b0;
    mstore(2'b01, 10'd0, 24'h11);
    mstore(2'b11, 10'd0, 24'h22);
    if (acc_q.size() == 3 && wd_q.size() == 2) begin
      chk("b2b_gap1", acc_q[1] - acc_q[0], 3);
      chk("b2b_gap2", acc_q[2] - acc_q[1], 3);
      chk("b2b_wd_gap", wd_q[1] - wd_q[0], 3);
    end else chk("b2b_counts", {acc_q.size(), wd_q.size()}, {32'd3, 32'd2});
    xfer(1'b1, 2'b00, 10'd1023, 24'hFFFFFF, 0, rd);
    xfer(1'b0, 2'b00, 10'd1023, 24'h0, 1, rd);
    chk("wrap_top", rd, 24'hFFFFFF);
    xfer(1'b0, 2'b00, 10'd0, 24'h0, 0, rd);
    chk("wrap_zero_untouched", rd, 24'h110022);
    xfer(1'b1, 2'b00, 10'd9, 24'h123456, 0, rd);
    before9 = mload(2'b00, 10'd9);
    wd_q.delete();
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_rgb = 2'b01;
    bus.req_addr = 10'd9;
    bus.req_wdata = 24'h000055;
    tick();
    bus.req_valid = 1'b0;
    chk("rm_accepted", bus.req_ready, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_ready", bus.req_ready, 1);
    chk("rm_outputs", {bus.rsp_valid, bus.wr_done}, 0);
    chk("rm_rsp_data", bus.rsp_data, 0);
    tick();
    chk("rm_ready_after", bus.req_ready, 1);
    tick();
    chk("rm_no_wr_done", wd_q.size(), 0);
    xfer(1'b0, 2'b00, 10'd9, 24'h0, 0, rd);
    chk("rm_addr9_kept", rd, before9);
    for (int t = 0; t < 60; t++) begin
      xfer(1'($urandom), 2'($urandom), pool[$urandom_range(0, 7)], 24'($urandom),
           int'($urandom_range(0, 3)), rd);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
